// File: rtl/div_32.sv
// Multi-cycle restoring divider for the ALU: one quotient bit per clock, signed or unsigned.
// Quotient drives the LO path, remainder the HI path; launched by start, finished by done.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] b_reg,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] hi_r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's-complement negation, applied only when the sign flag asks for it.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + ONE_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_lat_r;
  logic [WIDTH-1:0] dmag_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic             qneg_r;
  logic             rneg_r;
  logic             dz_pend_r;
  logic [WIDTH-1:0] lo_q_r;
  logic [WIDTH-1:0] hi_r_r;
  logic             busy_r;
  logic             done_r;
  logic             dz_flag_r;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   trial_s;
  logic             trial_neg_s;

  // Operand magnitudes at launch and the trial subtraction for the current step.
  always_comb begin
    a_mag_s     = ZERO_W;
    b_mag_s     = ZERO_W;
    rem_shift_s = {(WIDTH+1){1'b0}};
    trial_s     = {(WIDTH+1){1'b0}};
    trial_neg_s = 1'b0;
    a_mag_s     = cond_neg(a_reg, signed_op & a_reg[WIDTH-1]);
    b_mag_s     = cond_neg(b_reg, signed_op & b_reg[WIDTH-1]);
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    // The shifted remainder is below twice the divisor, so WIDTH+1 bits hold the sign.
    trial_s     = rem_shift_s - {1'b0, dmag_r};
    trial_neg_s = trial_s[WIDTH];
  end

  // Divider sequencer: launch, WIDTH shift-subtract steps, sign fix-up, done pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r   <= IDLE;
      count_r   <= CNT_ZERO;
      a_lat_r   <= ZERO_W;
      dmag_r    <= ZERO_W;
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
      dz_pend_r <= 1'b0;
      lo_q_r    <= ZERO_W;
      hi_r_r    <= ZERO_W;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_flag_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_lat_r   <= a_reg;
            dmag_r    <= b_mag_s;
            rem_r     <= ZERO_W;
            quo_r     <= a_mag_s;
            qneg_r    <= signed_op & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
            rneg_r    <= signed_op & a_reg[WIDTH-1];
            dz_pend_r <= (b_reg == ZERO_W);
            count_r   <= CNT_LOAD;
            busy_r    <= 1'b1;
            state_r   <= (b_reg == ZERO_W) ? FIXUP : ITER;
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          rem_r   <= trial_neg_s ? rem_shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
          quo_r   <= {quo_r[WIDTH-2:0], ~trial_neg_s};
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= FIXUP;
          end else begin
            state_r <= ITER;
          end
        end
        FIXUP: begin
          if (dz_pend_r) begin
            lo_q_r    <= ONES_W;
            hi_r_r    <= a_lat_r;
            dz_flag_r <= 1'b1;
          end else begin
            lo_q_r    <= cond_neg(quo_r, qneg_r);
            hi_r_r    <= cond_neg(rem_r, rneg_r);
            dz_flag_r <= 1'b0;
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign lo_q        = lo_q_r;
  assign hi_r        = hi_r_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dz_flag_r;

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: directed vector table, random ops against an
// arithmetic reference, and hand-written busy-rejection and mid-operation reset sequences.
module tb_div_32;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic        signed_op;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] lo_q;
  logic [31:0] hi_r;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_pass;
  int n_total;

  div_32 #(.WIDTH(32)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .signed_op(signed_op),
    .a_reg(a_reg), .b_reg(b_reg), .lo_q(lo_q), .hi_r(hi_r),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Call at #1 after a posedge with the divider idle; returns after the done cycle plus one.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output int bcnt);
    start = 1'b1; signed_op = s; a_reg = a; b_reg = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    q = lo_q; r = hi_r; dz = div_by_zero;
    @(posedge clk); #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] q, r, eq, er;
    logic        dz, edz;
    int          lat, bcnt, ndone;

    n_pass = 0; n_total = 0;
    clr_n = 1'b0; start = 1'b0; signed_op = 1'b0; a_reg = 32'd0; b_reg = 32'd0;

    tbl.push_back('{1'b1, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0});
    tbl.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,        1'b0});
    tbl.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 32'd1,        1'b0});
    tbl.push_back('{1'b1, 32'hFFFF_FFFF,  32'd2,        32'd0,         32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1});
    tbl.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0});
    tbl.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0});
    tbl.push_back('{1'b1, 32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1});
    tbl.push_back('{1'b0, 32'd7,          32'd7,        32'd1,         32'd0,        1'b0});

    #12;
    chk("rst_lo_q", lo_q, 32'd0);
    chk("rst_hi_r", hi_r, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, q, r, dz, lat, bcnt);
      chk($sformatf("vec%0d_lo_q", i), q, tbl[i].q);
      chk($sformatf("vec%0d_hi_r", i), r, tbl[i].r);
      chk($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, tbl[i].dz});
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].dz ? 32'd1 : 32'd33);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].dz ? 32'd0 : 32'd32);
    end

    for (int k = 0; k < 40; k++) begin
      logic        rs;
      logic [31:0] ra, rb;
      rs = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      model(rs, ra, rb, eq, er, edz);
      run_op(rs, ra, rb, q, r, dz, lat, bcnt);
      chk($sformatf("rnd%0d_lo_q", k), q, eq);
      chk($sformatf("rnd%0d_hi_r", k), r, er);
      chk($sformatf("rnd%0d_dz", k), {31'd0, dz}, {31'd0, edz});
      chk($sformatf("rnd%0d_latency", k), lat, edz ? 32'd1 : 32'd33);
    end

    // Busy rejection: a second start during ITER must not disturb the first operation.
    run_op(1'b0, 32'd7, 32'd7, q, r, dz, lat, bcnt);
    start = 1'b1; signed_op = 1'b1; a_reg = 32'd100; b_reg = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; a_reg = 32'd9; b_reg = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_lo_q_iter", lo_q, 32'd1);
    chk("busy_at_edge10", {31'd0, busy}, 32'd1);
    lat = 10;
    while (lat < 100 && !done) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rej_latency", lat, 32'd33);
    chk("rej_lo_q", lo_q, 32'd14);
    chk("rej_hi_r", hi_r, 32'd2);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rej_no_second_done", ndone, 32'd0);

    // Reset between edges during ITER abandons the operation.
    start = 1'b1; signed_op = 1'b1; a_reg = 32'd100; b_reg = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    chk("midrst_lo_q", lo_q, 32'd0);
    chk("midrst_hi_r", hi_r, 32'd0);
    chk("midrst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    run_op(1'b1, 32'd50, 32'd5, q, r, dz, lat, bcnt);
    chk("post_rst_lo_q", q, 32'd10);
    chk("post_rst_hi_r", r, 32'd0);
    chk("post_rst_latency", lat, 32'd33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
